// File: rtl/lsu_dcache_ctrl.sv
// Memory-stage load/store controller: runs one data-cache transaction per execute-stage
// request, handling store lane masking, load lane extraction/extension and misalignment.
module lsu_dcache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EX_LdStFlag,
  input  logic [ADDR_WIDTH-1:0] EX_AluData,
  input  logic [DATA_WIDTH-1:0] EX_StData,
  input  logic [2:0]            EX_LdType,
  input  logic [1:0]            EX_StType,
  output logic                  Dcache_Req,
  output logic                  Dcache_We,
  output logic [ADDR_WIDTH-1:0] Dcache_Addr,
  output logic [DATA_WIDTH-1:0] Dcache_WrData,
  output logic [3:0]            Dcache_WrMask,
  input  logic [DATA_WIDTH-1:0] Dcache_RdData,
  input  logic                  Dcache_Ack,
  output logic                  Mem_DcacheEN,
  output logic [DATA_WIDTH-1:0] Mem_LdData,
  output logic                  Mem_Stall,
  output logic                  Mem_MisalignExc
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LW   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LB   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LBU  = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SW   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SB   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  ld_lat;
  logic [1:0]  off_lat;

  logic        is_load;
  logic        ld_ok;
  logic        is_store;
  logic        misalign;
  logic        goes_req;
  logic [1:0]  st_eff;
  logic [1:0]  off_in;

  function automatic logic [3:0] store_mask(input logic [1:0] st, input logic [1:0] off);
    case (st)
      ST_SW:   return 4'b1111;
      ST_SH:   return 4'b0011 << {off[1], 1'b0};
      ST_SB:   return 4'b0001 << off;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] st,
                                                       input logic [DATA_WIDTH-1:0] d);
    case (st)
      ST_SW:   return d;
      ST_SH:   return {(DATA_WIDTH/16){d[15:0]}};
      ST_SB:   return {(DATA_WIDTH/8){d[7:0]}};
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] ld,
                                                        input logic [1:0] off,
                                                        input logic [DATA_WIDTH-1:0] rd);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    sh = rd >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (ld)
      LD_LB:   return {{(DATA_WIDTH-8){b[7]}}, b};
      LD_LH:   return {{(DATA_WIDTH-16){h[15]}}, h};
      LD_LBU:  return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      LD_LHU:  return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Request decode: a load type wins over a simultaneous store type
  always_comb begin
    off_in   = EX_AluData[1:0];
    is_load  = (EX_LdType != LD_NONE);
    ld_ok    = (EX_LdType >= LD_LW) && (EX_LdType <= LD_LBU);
    is_store = !is_load && (EX_StType != ST_NONE);
    st_eff   = is_store ? EX_StType : ST_NONE;
    misalign = 1'b0;
    if (is_load) begin
      if (EX_LdType == LD_LW)
        misalign = (off_in != 2'b00);
      else if (EX_LdType == LD_LH || EX_LdType == LD_LHU)
        misalign = off_in[0];
    end else if (is_store) begin
      if (EX_StType == ST_SW)
        misalign = (off_in != 2'b00);
      else if (EX_StType == ST_SH)
        misalign = off_in[0];
    end
    goes_req = (ld_ok || is_store) && !misalign;
  end

  assign Mem_Stall = ((state == S_IDLE) && EX_LdStFlag) || (state == S_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ld_lat          <= LD_NONE;
      off_lat         <= 2'b00;
      Dcache_Req      <= 1'b0;
      Dcache_We       <= 1'b0;
      Dcache_Addr     <= '0;
      Dcache_WrData   <= '0;
      Dcache_WrMask   <= 4'b0000;
      Mem_DcacheEN    <= 1'b0;
      Mem_MisalignExc <= 1'b0;
      Mem_LdData      <= '0;
    end else begin
      Mem_DcacheEN    <= 1'b0;
      Mem_MisalignExc <= 1'b0;
      case (state)
        // Accept: latch the access and decide whether a cache request is needed
        S_IDLE: begin
          if (EX_LdStFlag) begin
            ld_lat  <= ld_ok ? EX_LdType : LD_NONE;
            off_lat <= off_in;
            if (misalign) begin
              state           <= S_DONE;
              Mem_DcacheEN    <= 1'b1;
              Mem_MisalignExc <= 1'b1;
            end else if (goes_req) begin
              state         <= S_REQ;
              Dcache_Req    <= 1'b1;
              Dcache_We     <= is_store;
              Dcache_Addr   <= {EX_AluData[ADDR_WIDTH-1:2], 2'b00};
              Dcache_WrData <= store_data(st_eff, EX_StData);
              Dcache_WrMask <= store_mask(st_eff, off_in);
            end else begin
              state        <= S_DONE;
              Mem_DcacheEN <= 1'b1;
            end
          end
        end
        // Request held stable until the cache acknowledges
        S_REQ: begin
          if (Dcache_Ack) begin
            Dcache_Req   <= 1'b0;
            Dcache_We    <= 1'b0;
            Mem_DcacheEN <= 1'b1;
            state        <= S_DONE;
            if (ld_lat != LD_NONE)
              Mem_LdData <= load_extend(ld_lat, off_lat, Dcache_RdData);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dcache_ctrl.sv
// Directed bench for lsu_dcache_ctrl: a table of single accesses plus hand-written
// sequences for mid-request reset, stray acks and back-to-back accesses.
module tb_lsu_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_LdStFlag;
  logic [31:0] EX_AluData;
  logic [31:0] EX_StData;
  logic [2:0]  EX_LdType;
  logic [1:0]  EX_StType;
  logic        Dcache_Req;
  logic        Dcache_We;
  logic [31:0] Dcache_Addr;
  logic [31:0] Dcache_WrData;
  logic [3:0]  Dcache_WrMask;
  logic [31:0] Dcache_RdData;
  logic        Dcache_Ack;
  logic        Mem_DcacheEN;
  logic [31:0] Mem_LdData;
  logic        Mem_Stall;
  logic        Mem_MisalignExc;

  int checks = 0;
  int errors = 0;

  lsu_dcache_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_LdStFlag(EX_LdStFlag), .EX_AluData(EX_AluData), .EX_StData(EX_StData),
    .EX_LdType(EX_LdType), .EX_StType(EX_StType),
    .Dcache_Req(Dcache_Req), .Dcache_We(Dcache_We), .Dcache_Addr(Dcache_Addr),
    .Dcache_WrData(Dcache_WrData), .Dcache_WrMask(Dcache_WrMask),
    .Dcache_RdData(Dcache_RdData), .Dcache_Ack(Dcache_Ack),
    .Mem_DcacheEN(Mem_DcacheEN), .Mem_LdData(Mem_LdData),
    .Mem_Stall(Mem_Stall), .Mem_MisalignExc(Mem_MisalignExc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          wt;
    logic        req;
    logic        we;
    logic [31:0] caddr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        exc;
    logic [31:0] ldv;
  } vec_t;

  vec_t vecs[16];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_req"}, Dcache_Req, 1'b0);
    chk1({tag, "_we"}, Dcache_We, 1'b0);
    chk32({tag, "_addr"}, Dcache_Addr, 32'h0);
    chk32({tag, "_wdata"}, Dcache_WrData, 32'h0);
    chk32({tag, "_mask"}, {28'd0, Dcache_WrMask}, 32'h0);
    chk1({tag, "_en"}, Mem_DcacheEN, 1'b0);
    chk1({tag, "_exc"}, Mem_MisalignExc, 1'b0);
    chk32({tag, "_lddata"}, Mem_LdData, 32'h0);
    chk1({tag, "_stall"}, Mem_Stall, 1'b0);
  endtask

  task automatic run_txn(input int idx, input vec_t t);
    int cyc;
    int nreq;
    bit done;
    @(negedge clk);
    EX_LdStFlag = 1'b1;
    EX_LdType   = t.ld;
    EX_StType   = t.st;
    EX_AluData  = t.addr;
    EX_StData   = t.sd;
    Dcache_Ack  = 1'b0;
    #1 chk1($sformatf("v%0d_stall_c0", idx), Mem_Stall, 1'b1);
    cyc  = 0;
    nreq = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      Dcache_Ack    = 1'b0;
      Dcache_RdData = 32'h5A5A5A5A;
      // inputs wander while the access is outstanding; latched fields must not follow
      EX_AluData = t.addr ^ 32'h0000_0F03;
      EX_StData  = ~t.sd;
      EX_LdType  = t.ld ^ 3'b111;
      EX_StType  = ~t.st;
      if (Mem_DcacheEN) begin
        done = 1;
      end else begin
        chk1($sformatf("v%0d_req_c%0d", idx, cyc), Dcache_Req, t.req);
        chk1($sformatf("v%0d_stall_c%0d", idx, cyc), Mem_Stall, 1'b1);
        if (t.req && Dcache_Req) begin
          nreq++;
          chk1($sformatf("v%0d_we", idx), Dcache_We, t.we);
          chk32($sformatf("v%0d_addr", idx), Dcache_Addr, t.caddr);
          chk32($sformatf("v%0d_wdata", idx), Dcache_WrData, t.wdata);
          chk32($sformatf("v%0d_mask", idx), {28'd0, Dcache_WrMask}, {28'd0, t.mask});
          if (nreq == t.wt + 1) begin
            Dcache_Ack    = 1'b1;
            Dcache_RdData = t.rd;
          end
        end
      end
    end
    chk1($sformatf("v%0d_completed", idx), done, 1'b1);
    chk32($sformatf("v%0d_latency", idx), 32'(cyc), t.req ? 32'(t.wt + 2) : 32'd1);
    chk32($sformatf("v%0d_req_cycles", idx), 32'(nreq), t.req ? 32'(t.wt + 1) : 32'd0);
    chk1($sformatf("v%0d_exc", idx), Mem_MisalignExc, t.exc);
    chk32($sformatf("v%0d_lddata", idx), Mem_LdData, t.ldv);
    chk1($sformatf("v%0d_done_stall", idx), Mem_Stall, 1'b0);
    chk1($sformatf("v%0d_done_req", idx), Dcache_Req, 1'b0);
    EX_LdStFlag = 1'b0;
    @(negedge clk);
    chk1($sformatf("v%0d_en_single", idx), Mem_DcacheEN, 1'b0);
    chk1($sformatf("v%0d_exc_single", idx), Mem_MisalignExc, 1'b0);
    chk1($sformatf("v%0d_idle_stall", idx), Mem_Stall, 1'b0);
  endtask

  initial begin
    vec_t   post;
    bit [6:1] ereq;
    bit [6:1] een;
    int     pulses;

    //               ld    st    addr          sd            rd            wt req we caddr         wdata         mask     exc ldv
    vecs[0]  = '{3'd1, 2'd0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 0, 32'hDEADBEEF};
    vecs[1]  = '{3'd3, 2'd0, 32'h0000_0203, 32'h0,        32'h80FF0000, 0, 1, 0, 32'h0000_0200, 32'h0,        4'b0000, 0, 32'hFFFFFF80};
    vecs[2]  = '{3'd5, 2'd0, 32'h0000_0203, 32'h0,        32'h80FF0000, 0, 1, 0, 32'h0000_0200, 32'h0,        4'b0000, 0, 32'h00000080};
    vecs[3]  = '{3'd0, 2'd2, 32'h0000_0102, 32'h1234ABCD, 32'h0,        1, 1, 1, 32'h0000_0100, 32'hABCDABCD, 4'b1100, 0, 32'h00000080};
    vecs[4]  = '{3'd0, 2'd3, 32'h0000_0101, 32'h00000077, 32'h0,        0, 1, 1, 32'h0000_0100, 32'h77777777, 4'b0010, 0, 32'h00000080};
    vecs[5]  = '{3'd1, 2'd0, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 0, 32'h0,         32'h0,        4'b0000, 1, 32'h00000080};
    vecs[6]  = '{3'd2, 2'd0, 32'h0000_0102, 32'h0,        32'h80011234, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 0, 32'hFFFF8001};
    vecs[7]  = '{3'd4, 2'd0, 32'h0000_0102, 32'h0,        32'h80011234, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 0, 32'h00008001};
    vecs[8]  = '{3'd0, 2'd1, 32'h0000_00FC, 32'hCAFEF00D, 32'h0,        2, 1, 1, 32'h0000_00FC, 32'hCAFEF00D, 4'b1111, 0, 32'h00008001};
    vecs[9]  = '{3'd0, 2'd2, 32'h0000_0101, 32'h0000FFFF, 32'h0,        0, 0, 0, 32'h0,         32'h0,        4'b0000, 1, 32'h00008001};
    vecs[10] = '{3'd2, 2'd0, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 0, 32'h0,         32'h0,        4'b0000, 1, 32'h00008001};
    vecs[11] = '{3'd3, 2'd0, 32'h0000_0001, 32'h0,        32'h00007F00, 0, 1, 0, 32'h0000_0000, 32'h0,        4'b0000, 0, 32'h0000007F};
    vecs[12] = '{3'd2, 2'd1, 32'h0000_0100, 32'h99999999, 32'h0000FFFE, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 0, 32'hFFFFFFFE};
    vecs[13] = '{3'd6, 2'd0, 32'h0000_0103, 32'h0,        32'h0,        0, 0, 0, 32'h0,         32'h0,        4'b0000, 0, 32'hFFFFFFFE};
    vecs[14] = '{3'd1, 2'd0, 32'h0000_0004, 32'h0,        32'h11112222, 1, 1, 0, 32'h0000_0004, 32'h0,        4'b0000, 0, 32'h11112222};
    vecs[15] = '{3'd0, 2'd3, 32'h0000_0003, 32'h123456A5, 32'h0,        0, 1, 1, 32'h0000_0000, 32'hA5A5A5A5, 4'b1000, 0, 32'h11112222};

    rst_n         = 1'b0;
    EX_LdStFlag   = 1'b0;
    EX_AluData    = 32'h0;
    EX_StData     = 32'h0;
    EX_LdType     = 3'd0;
    EX_StType     = 2'd0;
    Dcache_RdData = 32'h0;
    Dcache_Ack    = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_txn(i, vecs[i]);

    // Stray acks while idle must not start or complete anything
    @(negedge clk);
    Dcache_Ack    = 1'b1;
    Dcache_RdData = 32'h0F0F0F0F;
    repeat (2) begin
      @(negedge clk);
      chk1("stray_ack_en", Mem_DcacheEN, 1'b0);
      chk1("stray_ack_req", Dcache_Req, 1'b0);
      chk32("stray_ack_lddata", Mem_LdData, 32'h11112222);
    end
    Dcache_Ack = 1'b0;

    // Reset in the middle of an outstanding request
    @(negedge clk);
    EX_LdStFlag = 1'b1;
    EX_LdType   = 3'd1;
    EX_StType   = 2'd0;
    EX_AluData  = 32'h0000_0300;
    @(negedge clk);
    chk1("midreset_req_before", Dcache_Req, 1'b1);
    EX_LdStFlag = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    post = '{3'd1, 2'd0, 32'h0000_0300, 32'h0, 32'h0BADF00D, 0, 1, 0, 32'h0000_0300, 32'h0, 4'b0000, 0, 32'h0BADF00D};
    run_txn(16, post);

    // Back-to-back SW then LH with the flag held high throughout
    ereq   = 6'b001001;
    een    = 6'b010010;
    pulses = 0;
    @(negedge clk);
    EX_LdStFlag = 1'b1;
    EX_LdType   = 3'd0;
    EX_StType   = 2'd1;
    EX_AluData  = 32'h0000_0040;
    EX_StData   = 32'h01020304;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      Dcache_Ack = 1'b0;
      chk1($sformatf("b2b_req_c%0d", c), Dcache_Req, ereq[c]);
      chk1($sformatf("b2b_en_c%0d", c), Mem_DcacheEN, een[c]);
      if (Mem_DcacheEN) pulses++;
      case (c)
        1: begin
          chk1("b2b_sw_we", Dcache_We, 1'b1);
          chk32("b2b_sw_addr", Dcache_Addr, 32'h0000_0040);
          chk32("b2b_sw_wdata", Dcache_WrData, 32'h01020304);
          chk32("b2b_sw_mask", {28'd0, Dcache_WrMask}, 32'h0000000F);
          Dcache_Ack = 1'b1;
        end
        2: begin
          EX_LdType  = 3'd2;
          EX_StType  = 2'd0;
          EX_AluData = 32'h0000_0042;
        end
        3: chk1("b2b_idle_stall", Mem_Stall, 1'b1);
        4: begin
          chk1("b2b_lh_we", Dcache_We, 1'b0);
          chk32("b2b_lh_addr", Dcache_Addr, 32'h0000_0040);
          Dcache_Ack    = 1'b1;
          Dcache_RdData = 32'hBEEF0000;
        end
        5: begin
          chk32("b2b_lh_lddata", Mem_LdData, 32'hFFFFBEEF);
          EX_LdStFlag = 1'b0;
        end
        default: chk1("b2b_end_stall", Mem_Stall, 1'b0);
      endcase
    end
    chk32("b2b_pulses", 32'(pulses), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dcache_ctrl.md
# lsu_dcache_ctrl

Memory-stage load/store controller that answers the execute stage's load/store request. It sees `EX_LdStFlag` high, then runs one data-cache transaction: store byte-masking, load byte-lane extraction and sign/zero extension, and misalignment detection. It returns `Mem_DcacheEN` to the execute stage to end the request. While the access is outstanding it stalls the pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data path width.
- `ADDR_WIDTH`, 32, address width.

Ports:
- Clock and reset (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `EX_LdStFlag` in 1: execute stage has an unserved load/store.
- `EX_AluData` in ADDR_WIDTH: effective address.
- `EX_StData` in DATA_WIDTH: forwarded rs2 store data.
- `EX_LdType` in 3: 0 none, 1 LW, 2 LH, 3 LB, 4 LHU, 5 LBU.
- `EX_StType` in 2: 0 none, 1 SW, 2 SH, 3 SB.
- `Dcache_Req` out 1: request valid.
- `Dcache_We` out 1: 1 = write.
- `Dcache_Addr` out ADDR_WIDTH: word-aligned address, `{addr[31:2],2'b00}`.
- `Dcache_WrData` out DATA_WIDTH: lane-replicated store data.
- `Dcache_WrMask` out 4: byte enables.
- `Dcache_RdData` in DATA_WIDTH: read word, valid only in the cycle `Dcache_Ack` is high.
- `Dcache_Ack` in 1: transaction complete.
- `Mem_DcacheEN` out 1: one-cycle completion pulse back to execute.
- `Mem_LdData` out DATA_WIDTH: extended load result.
- `Mem_Stall` out 1: freeze IF/ID/EX.
- `Mem_MisalignExc` out 1: one-cycle misaligned-access pulse.

## Operation
States: IDLE, REQ, DONE. All are registered.

IDLE
- On `EX_LdStFlag`=1, latch address, types and store data.
- Misaligned access goes to DONE with `Mem_MisalignExc`=1 and issues no cache request. Misaligned means:
  - LW/SW with `addr[1:0]`≠0;
  - LH/LHU/SH with `addr[0]`≠0.
- Aligned access goes to REQ.

REQ
- Drive `Dcache_Req`=1 from the latched fields. Hold them stable until `Dcache_Ack`.
- On `Dcache_Ack`: capture `Mem_LdData` if the access is a load, then go to DONE.
- The ack may arrive in the first REQ cycle.

DONE
- `Mem_DcacheEN`=1 for exactly one cycle, then go to IDLE.

Load extraction
- Shift `Dcache_RdData` right by `addr[1:0]*8`.
- LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.

Store data and masks
- SW: mask 1111, data = the full word.
- SH: mask `0011<<(addr[1]*2)`, data `{2{d[15:0]}}`.
- SB: mask `0001<<addr[1:0]`, data `{4{d[7:0]}}`.
- `Dcache_We` = 1 for a store, 0 for a load.

Other rules
- LdType≠0 and StType≠0 together: treat as a load.
- LdType 6/7 with StType 0: no request; go straight to DONE with no exception.
- `Mem_LdData` holds its value until the next load completes. Stores and misaligned accesses do not update it.
- `Mem_Stall` = (IDLE & `EX_LdStFlag`) | REQ. It is combinational from the state and is 0 in DONE.

## Timing
- Reset, applied asynchronously at any time:
  - state goes to IDLE;
  - `Dcache_Req`, `Dcache_We`, `Mem_DcacheEN`, `Mem_MisalignExc` = 0;
  - `Dcache_Addr`, `Dcache_WrData`, `Dcache_WrMask`, `Mem_LdData` = 0;
  - a REQ in progress is dropped immediately.
- Latency, flag seen in cycle 0:
  - aligned access with ack in cycle 1: `Mem_DcacheEN` in cycle 2;
  - each wait cycle before ack adds one cycle;
  - misaligned access: `Mem_DcacheEN` and `Mem_MisalignExc` in cycle 1.
- The execute stage drops `EX_LdStFlag` combinationally when `Mem_DcacheEN`=1. The pipeline advances at the end of DONE, so the next instruction's flag is sampled in the following IDLE cycle. Back-to-back accesses therefore have one IDLE cycle between them.
- `EX_LdStFlag` is ignored outside IDLE. Latched fields are unaffected by input changes during REQ.
- `Dcache_Ack` outside REQ is ignored.

## Test plan
- LW at 0x100, ack after 3 wait cycles with RdData 0xDEADBEEF:
  - `Dcache_Req` high for 4 cycles with Addr 0x100;
  - `Mem_Stall` high for 5 cycles;
  - then `Mem_LdData`=0xDEADBEEF and a single `Mem_DcacheEN` pulse.
- LB at 0x203 and LBU at 0x203, RdData 0x80FF_0000, ack immediate:
  - LB gives 0xFFFFFF80;
  - LBU gives 0x00000080;
  - completion 2 cycles after the flag.
- SH at 0x102 with data 0x1234ABCD: Mask 1100, WrData 0xABCDABCD, We=1. SB at 0x101 with data 0x77: Mask 0010, WrData 0x77777777.
- LW at 0x102 (misaligned):
  - no `Dcache_Req`;
  - `Mem_MisalignExc` and `Mem_DcacheEN` both pulse in cycle 1;
  - `Mem_LdData` unchanged.
- `rst_n` asserted mid-REQ: `Dcache_Req` falls with no clock edge, state returns to IDLE, all outputs read 0. A later LW completes normally.
- Back-to-back SW then LH with `EX_LdStFlag` held high: two distinct requests, one IDLE cycle between them, two `Mem_DcacheEN` pulses.
